// File: rtl/data_sram_resp.sv
// data_sram_resp
// Responder for the CPU data SRAM interface. Every cycle carries a request.
// Read data is registered and appears the cycle after the address is driven.
// Address decode:
//   addr[31:16] == MMIO_BASE  -> register window (LED, optional TIMER)
//   otherwise                 -> word RAM indexed by addr[ADDR_W+1:2]
// Reads are write-first: a write in the same cycle returns its own wdata.
//
// Optional feature macro: DSRAM_TIMER_EN
//   Defined:   free-running 32-bit TIMER at offset 16'he000.
//   Undefined: offset 16'he000 is unmapped (reads 0, writes ignored).
//
// Ports:
//   clk              sole clock, posedge
//   reset            asynchronous, active-high
//   data_sram_we     write strobe
//   data_sram_addr   byte address, [1:0] ignored
//   data_sram_wdata  write data
//   data_sram_rdata  registered read data
//   led              LED register contents
module data_sram_resp #(
    parameter int          ADDR_W    = 16,
    parameter logic [15:0] MMIO_BASE = 16'hbfaf
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led
);

    localparam logic [15:0] OFF_LED   = 16'h8000;
    localparam logic [15:0] OFF_TIMER = 16'he000;

    // RAM contents survive reset, so the array has no reset term.
    logic [31:0] mem [2**ADDR_W];

    logic              mmio_hit;
    logic [15:0]       mmio_off;
    logic [ADDR_W-1:0] ram_idx;

    logic [31:0] rdata_d, rdata_q;
    logic [15:0] led_d, led_q;

    assign mmio_hit = (data_sram_addr[31:16] == MMIO_BASE);
    assign mmio_off = data_sram_addr[15:0];
    assign ram_idx  = data_sram_addr[ADDR_W+1:2];

    // Byte-lane bits play no part in a word-wide access.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^data_sram_addr[1:0];

`ifdef DSRAM_TIMER_EN
    logic [31:0] timer_d, timer_q;

    // A write loads the counter and takes priority over the increment.
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (data_sram_we && mmio_hit && mmio_off == OFF_TIMER)
            timer_d = data_sram_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) timer_q <= 32'd0;
        else       timer_q <= timer_d;
    end
`endif

    always_comb begin
        led_d   = led_q;
        rdata_d = 32'd0;
        if (mmio_hit) begin
            case (mmio_off)
                OFF_LED: begin
                    if (data_sram_we) begin
                        led_d   = data_sram_wdata[15:0];
                        rdata_d = {16'd0, data_sram_wdata[15:0]};
                    end else begin
                        rdata_d = {16'd0, led_q};
                    end
                end
`ifdef DSRAM_TIMER_EN
                // Unwritten reads see the value held during the address cycle.
                OFF_TIMER: rdata_d = data_sram_we ? data_sram_wdata : timer_q;
`endif
                default: rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = data_sram_we ? data_sram_wdata : mem[ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && data_sram_we && !mmio_hit)
            mem[ram_idx] <= data_sram_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'd0;
            led_q   <= 16'd0;
        end else begin
            rdata_q <= rdata_d;
            led_q   <= led_d;
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led             = led_q;

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder side of the CPU data SRAM interface: accepts the core's `data_sram_we/addr/wdata` requests and returns `data_sram_rdata` one cycle later. It contains a word-addressed synchronous RAM plus a small memory-mapped register window (LED register, free-running timer). It replaces the bench-supplied data RAM model in the SoC wrapper beside the CPU top.

## Interface
Parameters:
- `ADDR_W`, 16, RAM index width; RAM holds 2^ADDR_W 32-bit words.
- `MMIO_BASE`, 16'hbfaf, value of `addr[31:16]` that selects the register window.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `data_sram_we`  in  1  write strobe for the current request.
- `data_sram_addr`  in  32  byte address; `[1:0]` ignored.
- `data_sram_wdata`  in  32  write data.
- `data_sram_rdata`  out  32  read data, registered, valid the cycle after the address.
- `led`  out  16  LED register contents.

## Operation
- Every cycle is a request; there is no valid/ready. The responder never stalls.
- Decode: `mmio_hit = (addr[31:16] == MMIO_BASE)`. Otherwise RAM access.
- RAM: index = `addr[ADDR_W+1:2]`; upper address bits above the index ignored (addresses alias modulo 2^(ADDR_W+2) bytes). Contents are not reset.
- RAM write: at posedge with `we=1` and `!mmio_hit`, `mem[index] <= wdata`.
- MMIO offsets (`addr[15:0]`):
  - 16'h8000 LED: RW; write stores `wdata[15:0]`; read returns `{16'b0, led}`.
  - 16'he000 TIMER: RW; 32-bit counter, increments by 1 every cycle, wraps 32'hffff_ffff -> 0. Write loads `wdata`; write has priority over increment in that cycle.
  - any other offset: reads 0, writes ignored.
- Read data: `rdata <=` selected source at each posedge, write-first: if `we=1` in the same cycle, `rdata <= wdata` for valid RAM, LED (zero-extended `wdata[15:0]`) and TIMER targets. Ignored-write offsets still read 0.
- Without a write, TIMER read returns the pre-edge counter value (the value present in the cycle the address is driven).

## Timing
- Read latency: exactly 1 cycle; `rdata` updates on every posedge regardless of `we`.
- Write takes effect at the posedge it is presented; a read of the same address in the next cycle returns the new value.
- Back-to-back write/read/write to one address: each cycle's `rdata` reflects the preceding cycle's request with write-first rule.
- Reset (asserted asynchronously, any time): `data_sram_rdata=0`, `led=0`, timer=0 immediately; RAM contents preserved. An access in flight when reset asserts is dropped (its rdata never appears). First cycle after deassertion: timer increments from 0; requests are accepted normally.
- While reset is high, writes are ignored and timer holds 0.

## Configuration
- `DSRAM_TIMER_EN` defined: TIMER register and counter present as above.
- Not defined: no counter logic; offset 16'he000 behaves as an unmapped offset (reads 0, writes ignored, including write-first path returning 0).

## Test plan
- Reset then write 32'hdead_beef to 0x0000_0010, next cycle read 0x0000_0010 -> `rdata` = 32'hdead_beef one cycle after the read address.
- Write 32'h1234_5678 to 0x0000_0010 with `ADDR_W=16`, read 0x0004_0010 -> 32'h1234_5678 (alias); read 0x0000_0014 -> unchanged prior value.
- Write 32'h0000_a5a5 to 0xbfaf_8000 -> `led`=16'ha5a5 after that edge, `rdata`=32'h0000_a5a5 next cycle (write-first); read 0xbfaf_4000 -> 0.
- With `DSRAM_TIMER_EN`: write 32'hffff_fffe to 0xbfaf_e000 at cycle N, read it in cycles N+1, N+2, N+3 -> `rdata` in N+2..N+4 = 32'hffff_fffe, 32'hffff_ffff, 32'h0000_0000.
- Without `DSRAM_TIMER_EN`: write then read 0xbfaf_e000 -> `rdata` always 0.
- Assert `reset` mid-stream after writing 0x55 to 0x20 and `led`=1 -> `rdata`=0, `led`=0 asynchronously; after release, read 0x20 -> 0x55.
